// File: rtl/fpu_pkg.sv
// Shared widths, constants and bundle types for the single-precision add path.
package fpu_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int MANT_W   = 23;
    localparam int XMANT_W  = 28;

    typedef struct packed {
        logic              sign;
        logic [7:0]        exp;
        logic [MANT_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic               in_sign;
        logic [7:0]         in_exp;
        logic [XMANT_W-1:0] in_mant;
    } norm_in_t;

endpackage

// File: rtl/lzc27.sv
// Combinational 27-bit leading-zero counter; all-zero input yields 27.
module lzc27 (
    input  logic [26:0] data,
    output logic [4:0]  count
);

    // Scan LSB to MSB so the highest set bit makes the final assignment.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (data[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalize + round-to-nearest-even for the single-precision add path.
// Define FPU_DENORM_EN to produce subnormals; otherwise tiny results flush to zero.
module fp_norm_round
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_inexact
);

    norm_in_t           in_bus;
    logic [4:0]         lz;
    logic [26:0]        s1_mant_next;
    logic signed [9:0]  s1_exp_next;
    logic               s1_zero_next;
    logic               s1_tiny_next;

    logic               s1_valid_reg;
    logic               s1_sign_reg;
    logic [26:0]        s1_mant_reg;
    logic signed [9:0]  s1_exp_reg;
    logic               s1_zero_reg;
    logic               s1_tiny_reg;

    logic               out_valid_reg;
    fp32_t              out_result_reg;
    logic               out_overflow_reg;
    logic               out_underflow_reg;
    logic               out_inexact_reg;

    logic               out_adv;
    logic               s1_adv;

    assign in_bus   = {in_sign, in_exp, in_mant};
    assign out_adv  = !out_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || out_adv;
    assign in_ready = s1_adv;

    lzc27 u_lzc (
        .data  (in_bus.in_mant[26:0]),
        .count (lz)
    );

    // Stage 1: bring the leading one to bit 26; a carry folds its dropped bit into sticky.
    always_comb begin
        s1_zero_next = (in_bus.in_mant == '0);
        if (in_bus.in_mant[27]) begin
            s1_mant_next = {in_bus.in_mant[27:2], |in_bus.in_mant[1:0]};
            s1_exp_next  = signed'({2'b00, in_bus.in_exp}) + 10'sd1;
        end else begin
            s1_mant_next = in_bus.in_mant[26:0] << lz;
            s1_exp_next  = signed'({2'b00, in_bus.in_exp}) - signed'({5'd0, lz});
        end
        s1_tiny_next = !s1_zero_next && (s1_exp_next <= 10'sd0);
    end

    logic [26:0]        rnd_mant;
    logic signed [9:0]  exp_pre;
    logic               rnd_g;
    logic               rnd_s;
    logic               rnd_l;
    logic               rnd_inc;
    logic               rnd_inexact;
    logic [24:0]        rnd_sum;
    logic signed [9:0]  exp_fin;
    logic [22:0]        frac_fin;
    fp32_t              result_next;
    logic               overflow_next;
    logic               underflow_next;
    logic               inexact_next;
`ifdef FPU_DENORM_EN
    logic signed [9:0]  den_sh_full;
    logic [4:0]         den_sh;
    logic [26:0]        den_lost_mask;
`endif

    // Stage 2: optional denormalizing shift, RNE increment, re-normalize, pack.
    always_comb begin
        rnd_mant = s1_mant_reg;
        exp_pre  = s1_exp_reg;
`ifdef FPU_DENORM_EN
        den_sh_full   = 10'sd1 - s1_exp_reg;
        den_sh        = (den_sh_full > 10'sd27) ? 5'd27 : den_sh_full[4:0];
        den_lost_mask = ~(27'h7FF_FFFF << den_sh);
        if (s1_tiny_reg) begin
            rnd_mant = (s1_mant_reg >> den_sh) | {26'd0, |(s1_mant_reg & den_lost_mask)};
            exp_pre  = 10'sd0;
        end
`endif
        rnd_g       = rnd_mant[2];
        rnd_s       = |rnd_mant[1:0];
        rnd_l       = rnd_mant[3];
        rnd_inc     = rnd_g && (rnd_s || rnd_l);
        rnd_inexact = rnd_g || rnd_s;
        rnd_sum     = {1'b0, rnd_mant[26:3]} + 25'(rnd_inc);

        if (rnd_sum[24]) begin
            frac_fin = rnd_sum[23:1];
            exp_fin  = exp_pre + 10'sd1;
        end else begin
            frac_fin = rnd_sum[22:0];
            exp_fin  = exp_pre;
        end
`ifdef FPU_DENORM_EN
        // A subnormal that rounds up into the hidden bit becomes the smallest normal.
        if (s1_tiny_reg) begin
            exp_fin = {9'd0, rnd_sum[23]};
        end
`endif

        result_next    = {s1_sign_reg, exp_fin[7:0], frac_fin};
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        inexact_next   = rnd_inexact;

        if (s1_zero_reg) begin
            result_next  = {s1_sign_reg, 31'b0};
            inexact_next = 1'b0;
        end else if (s1_tiny_reg) begin
`ifdef FPU_DENORM_EN
            underflow_next = rnd_inexact;
`else
            result_next    = {s1_sign_reg, 31'b0};
            underflow_next = 1'b1;
            inexact_next   = 1'b1;
`endif
        end else if (exp_fin >= 10'(EXP_MAX)) begin
            result_next   = {s1_sign_reg, 8'hFF, 23'b0};
            overflow_next = 1'b1;
            inexact_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg      <= 1'b0;
            out_valid_reg     <= 1'b0;
            out_result_reg    <= '0;
            out_overflow_reg  <= 1'b0;
            out_underflow_reg <= 1'b0;
            out_inexact_reg   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_sign_reg <= in_bus.in_sign;
                    s1_mant_reg <= s1_mant_next;
                    s1_exp_reg  <= s1_exp_next;
                    s1_zero_reg <= s1_zero_next;
                    s1_tiny_reg <= s1_tiny_next;
                end
            end
            if (out_adv) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_result_reg    <= result_next;
                    out_overflow_reg  <= overflow_next;
                    out_underflow_reg <= underflow_next;
                    out_inexact_reg   <= inexact_next;
                end
            end
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_result    = out_result_reg;
    assign out_overflow  = out_overflow_reg;
    assign out_underflow = out_underflow_reg;
    assign out_inexact   = out_inexact_reg;

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: expectations queued on accept, checked on drain.
module tb_fp_norm_round;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [27:0] in_mant = 28'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    exp_t sb[$];
    exp_t cur_exp;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_out  = 0;

    fp_norm_round dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] r, input logic o, input logic u, input logic i);
        exp_t e;
        e.res = r;
        e.ovf = o;
        e.unf = u;
        e.inx = i;
        return e;
    endfunction

`ifdef FPU_DENORM_EN
    localparam exp_t TINY_E = '{res: 32'h0040_0000, ovf: 1'b0, unf: 1'b0, inx: 1'b0};
`else
    localparam exp_t TINY_E = '{res: 32'h0000_0000, ovf: 1'b0, unf: 1'b1, inx: 1'b1};
`endif

    // One clock: observe both handshakes at the negedge, then return 1 time unit after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            n_out++;
            $display("out %0d: result=%h ovf=%b unf=%b inx=%b",
                     n_out, out_result, out_overflow, out_underflow, out_inexact);
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_output: got %h, required no output", out_result);
            end else begin
                e = sb.pop_front();
                if ({out_result, out_overflow, out_underflow, out_inexact} !== e) begin
                    n_miss++;
                    $display("FAIL scoreboard: got %h o%b u%b i%b, required %h o%b u%b i%b",
                             out_result, out_overflow, out_underflow, out_inexact,
                             e.res, e.ovf, e.unf, e.inx);
                end
            end
        end
        if (!rst && in_valid && in_ready) sb.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sg, input logic [7:0] ex, input logic [27:0] mt, input exp_t e);
        int   k;
        logic acc;
        k = 0;
        in_sign  = sg;
        in_exp   = ex;
        in_mant  = mt;
        cur_exp  = e;
        in_valid = 1'b1;
        do begin
            acc = in_ready;
            tick();
            k++;
        end while (!acc && k < 20);
        if (!acc) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && k < 20) begin
            tick();
            k++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, out_result, out_overflow, out_underflow, out_inexact} !==
            {1'b0, 1'b1, 32'h0, 3'b000}) begin
            n_miss++;
            $display("FAIL reset_state: got valid=%b ready=%b res=%h flags=%b%b%b, required 0 1 0 000",
                     out_valid, in_ready, out_result, out_overflow, out_underflow, out_inexact);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        send(1'b0, 8'd127, 28'd1 << 26, mk(32'h3F80_0000, 0, 0, 0));
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL latency_n1: out_valid=%b, required 0", out_valid);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_result !== 32'h3F80_0000) begin
            n_miss++;
            $display("FAIL latency_n2: valid=%b res=%h, required 1 3f800000", out_valid, out_result);
        end
        drain();
    endtask

    task automatic test_datapath();
        out_ready = 1'b1;
        send(1'b0, 8'd127, 28'd1 << 27, mk(32'h4000_0000, 0, 0, 0));
        send(1'b0, 8'd127, 28'd1 << 20, mk(32'h3C80_0000, 0, 0, 0));
        send(1'b0, 8'd127, (28'd1 << 26) | (28'd1 << 2), mk(32'h3F80_0000, 0, 0, 1));
        send(1'b0, 8'd127, (28'd1 << 26) | (28'd1 << 3) | (28'd1 << 2), mk(32'h3F80_0002, 0, 0, 1));
        send(1'b1, 8'd254, 28'd1 << 27, mk(32'hFF80_0000, 1, 0, 1));
        send(1'b0, 8'd1, 28'd1 << 25, TINY_E);
        send(1'b1, 8'd90, 28'd0, mk(32'h8000_0000, 0, 0, 0));
        drain();
    endtask

    task automatic test_backpressure();
        logic [27:0] bp_mant [4];
        exp_t        bp_exp  [4];
        logic [31:0] held;
        int          idx;
        int          k;
        logic        acc;
        bp_mant[0] = 28'd1 << 26;  bp_exp[0] = mk(32'h3F80_0000, 0, 0, 0);
        bp_mant[1] = 28'd1 << 27;  bp_exp[1] = mk(32'h4000_0000, 0, 0, 0);
        bp_mant[2] = 28'd1 << 20;  bp_exp[2] = mk(32'h3C80_0000, 0, 0, 0);
        bp_mant[3] = (28'd1 << 26) | (28'd1 << 3) | (28'd1 << 2);
        bp_exp[3]  = mk(32'h3F80_0002, 0, 0, 1);
        idx = 0;
        out_ready = 1'b0;
        in_sign = 1'b0;
        in_exp  = 8'd127;
        for (int c = 0; c < 4; c++) begin
            in_mant  = bp_mant[idx];
            cur_exp  = bp_exp[idx];
            in_valid = 1'b1;
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        n_vec++;
        if (idx !== 2 || in_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL bp_capacity: accepted=%0d in_ready=%b, required 2 0", idx, in_ready);
        end
        held = out_result;
        n_vec++;
        if (held !== 32'h3F80_0000) begin
            n_miss++;
            $display("FAIL bp_head: got %h, required 3f800000", held);
        end
        repeat (2) tick();
        n_vec++;
        if (out_result !== held || out_valid !== 1'b1) begin
            n_miss++;
            $display("FAIL bp_stable: got %h valid=%b, required %h 1", out_result, out_valid, held);
        end
        out_ready = 1'b1;
        k = 0;
        while (idx < 4 && k < 20) begin
            in_mant  = bp_mant[idx];
            cur_exp  = bp_exp[idx];
            in_valid = 1'b1;
            acc = in_ready;
            tick();
            if (acc) idx++;
            k++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (idx !== 4) begin
            n_miss++;
            $display("FAIL bp_resume: accepted=%0d, required 4", idx);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send(1'b0, 8'd127, 28'd1 << 26, mk(32'h3F80_0000, 0, 0, 0));
        send(1'b0, 8'd127, 28'd1 << 27, mk(32'h4000_0000, 0, 0, 0));
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_miss++;
            $display("FAIL mid_prefill: out_valid=%b, required 1", out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL mid_reset: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (2) tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL mid_flush: out_valid=%b, required 0", out_valid);
        end
        send(1'b1, 8'd130, 28'd1 << 26, mk(32'hC100_0000, 0, 0, 0));
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_datapath();
        test_backpressure();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
